// File: rtl/adrv9001_sync_seq.sv
// adrv9001_sync_seq
//   Power-up / resync sequencer for an ADRV9001 SSI link. On start it emits a
//   multi-chip sync pulse, waits a settle time, waits for the SSI lock, then
//   brings up the selected rx/tx channel enables one at a time, STAGGER cycles
//   apart. Lock loss while enabling or active drops every enable and flags err.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start/stop/abort  run request, orderly shutdown from ACTIVE, hard return
//   sync_len          mssi_sync pulse length (0 is treated as 1)
//   settle_len        settle cycles after the pulse (0 skips SETTLE)
//   en_mask           channel select {tx2, tx1, rx2, rx1}
//   lock_in           SSI lock status
//   mssi_sync         sync pulse to the transceiver
//   rx1_en..tx2_en    channel enables
//   busy, done, err   status; all outputs are registered
module adrv9001_sync_seq #(
  parameter int CNT_WIDTH    = 16,
  parameter int STAGGER      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] sync_len,
  input  logic [CNT_WIDTH-1:0] settle_len,
  input  logic [3:0]           en_mask,
  input  logic                 lock_in,
  output logic                 mssi_sync,
  output logic                 rx1_en,
  output logic                 rx2_en,
  output logic                 tx1_en,
  output logic                 tx2_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_SETTLE, S_WAIT, S_ENABLE, S_ACTIVE, S_ERROR
  } state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;      // SYNC / SETTLE down-counter
  logic [CNT_WIDTH-1:0] settle_q;   // settle length captured at start
  logic [TW-1:0]        tmo_q;      // cycles spent in WAIT_LOCK
  logic [7:0]           stg_q;      // cycles left until the next enable
  logic [3:0]           pend_q;     // selected channels not yet enabled
  logic [3:0]           en_q;
  logic                 mssi_q, busy_q, done_q, err_q;

  // Lowest pending channel: rx1 first, tx2 last; unselected ones cost nothing.
  logic [3:0] first_d;
  always_comb first_d = pend_q & (~pend_q + 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      stg_q    <= '0;
      pend_q   <= '0;
      en_q     <= '0;
      mssi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (abort) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      en_q    <= '0;
      mssi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_q  <= S_SYNC;
            // A zero length still produces a one-cycle pulse.
            cnt_q    <= (sync_len == '0) ? CNT_WIDTH'(1) : sync_len;
            settle_q <= settle_len;
            pend_q   <= en_mask;
            en_q     <= '0;
            mssi_q   <= 1'b1;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
          end
        end

        S_SYNC: begin
          if (cnt_q <= CNT_WIDTH'(1)) begin
            mssi_q <= 1'b0;
            if (settle_q == '0) begin
              state_q <= S_WAIT;
              tmo_q   <= '0;
            end else begin
              state_q <= S_SETTLE;
              cnt_q   <= settle_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end

        S_SETTLE: begin
          if (cnt_q <= CNT_WIDTH'(1)) begin
            state_q <= S_WAIT;
            tmo_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end
        end

        S_WAIT: begin
          if (lock_in) begin
            // The first selected channel comes up with ENABLE entry.
            state_q <= S_ENABLE;
            en_q    <= en_q | first_d;
            pend_q  <= pend_q & ~first_d;
            stg_q   <= 8'(STAGGER - 1);
          end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
            state_q <= S_ERROR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        S_ENABLE: begin
          if (!lock_in) begin
            state_q <= S_ERROR;
            en_q    <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (pend_q == '0) begin
            // Zero or one channel selected: leave after one ENABLE cycle.
            state_q <= S_ACTIVE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (stg_q == '0) begin
            en_q   <= en_q | first_d;
            pend_q <= pend_q & ~first_d;
            stg_q  <= 8'(STAGGER - 1);
            // done rises together with the last enable.
            if ((pend_q & ~first_d) == '0) begin
              state_q <= S_ACTIVE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            stg_q <= stg_q - 8'd1;
          end
        end

        S_ACTIVE: begin
          if (!lock_in) begin
            state_q <= S_ERROR;
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b1;
          end else if (stop) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            done_q  <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mssi_sync = mssi_q;
  assign rx1_en    = en_q[0];
  assign rx2_en    = en_q[1];
  assign tx1_en    = en_q[2];
  assign tx2_en    = en_q[3];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_adrv9001_sync_seq.sv
module tb_adrv9001_sync_seq;

  localparam int CW  = 8;
  localparam int STG = 4;
  localparam int LT  = 20;

  logic          clk = 1'b0;
  logic          rst, start, stop, abort, lock_in;
  logic [CW-1:0] sync_len, settle_len;
  logic [3:0]    en_mask;
  logic          mssi_sync, rx1_en, rx2_en, tx1_en, tx2_en, busy, done, err;

  int checks   = 0;
  int failures = 0;

  adrv9001_sync_seq #(.CNT_WIDTH(CW), .STAGGER(STG), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
    .sync_len(sync_len), .settle_len(settle_len), .en_mask(en_mask),
    .lock_in(lock_in), .mssi_sync(mssi_sync), .rx1_en(rx1_en),
    .rx2_en(rx2_en), .tx1_en(tx1_en), .tx2_en(tx2_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // {mssi_sync, tx2, tx1, rx2, rx1, busy, done, err}
  function automatic logic [7:0] obs();
    return {mssi_sync, tx2_en, tx1_en, rx2_en, rx1_en, busy, done, err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Timeline of a clean run, cycle k counted from the edge that accepts start:
  // pulse for S=max(sync,1) cycles, T settle cycles, one WAIT_LOCK cycle with
  // lock present, ENABLE entered at E; the i-th selected channel rises at
  // E+i*STG; done rises with the last enable, or at E+1 for 0/1 channels.
  function automatic int done_time(int s, int t, logic [3:0] m);
    int sp = (s == 0) ? 1 : s;
    int e  = sp + t + 2;
    int n  = $countones(m);
    return (n <= 1) ? e + 1 : e + (n - 1) * STG;
  endfunction

  function automatic logic [7:0] model(int k, int s, int t, logic [3:0] m);
    int sp = (s == 0) ? 1 : s;
    int e  = sp + t + 2;
    int d  = done_time(s, t, m);
    int idx = 0;
    logic [3:0] en = '0;
    for (int ch = 0; ch < 4; ch++)
      if (m[ch]) begin
        en[ch] = (k >= e + idx * STG);
        idx++;
      end
    return {(k >= 1 && k <= sp), en, (k >= 1 && k < d), (k >= d), 1'b0};
  endfunction

  // Full run with lock held high. Stray stop/start while busy must be ignored
  // and the config inputs are scrambled after acceptance.
  task automatic run_seq(input string tag, input int s, input int t,
                         input logic [3:0] m, input bit do_stop);
    int d = done_time(s, t, m);
    sync_len = CW'(s); settle_len = CW'(t); en_mask = m;
    start = 1'b1;
    cyc();
    start = 1'b0;
    sync_len = CW'($urandom); settle_len = CW'($urandom); en_mask = 4'($urandom);
    for (int k = 1; k <= d + 1; k++) begin
      chk(tag, obs(), model(k, s, t, m));
      stop  = (k == 1);
      start = (k == 2);
      cyc();
      stop  = 1'b0;
      start = 1'b0;
    end
    chk({tag, "_active"}, obs(), model(d + 2, s, t, m));
    if (do_stop) begin
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk({tag, "_stop"}, obs(), 8'h00);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; lock_in = 1'b1;
    sync_len = '0; settle_len = '0; en_mask = '0;
    cyc();
    cyc();
    chk("reset", obs(), 8'h00);
    rst = 1'b0;
    cyc();
    chk("idle", obs(), 8'h00);

    // Reference sequence: rx1 @7, rx2 @11, tx1 @15, tx2 @19, done @19.
    run_seq("ref_033", 3, 2, 4'hF, 1'b1);

    // Randomized runs, including zero lengths and empty masks.
    for (int r = 0; r < 8; r++)
      run_seq("rand", $urandom_range(0, 6), $urandom_range(0, 5),
              4'($urandom_range(0, 15)), 1'b1);
    run_seq("mask0", 2, 0, 4'h0, 1'b1);

    // All-ones pulse length runs the full 2^CW-1 cycles.
    run_seq("sat", (1 << CW) - 1, 1, 4'h2, 1'b1);

    // Lock timeout: WAIT_LOCK entered at cycle 2, err at 2+LT.
    lock_in = 1'b0; sync_len = 8'd1; settle_len = 8'd0; en_mask = 4'hF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 2 + LT + 3; k++) begin
      chk("timeout", obs(),
          {(k == 1), 4'b0000, (k < 2 + LT), 1'b0, (k >= 2 + LT)});
      cyc();
    end
    lock_in = 1'b1;
    run_seq("restart_err", 1, 1, 4'h9, 1'b1);

    // Lock loss in ACTIVE with mask 0x5, then rerun from ERROR.
    run_seq("lockloss", 2, 1, 4'h5, 1'b0);
    lock_in = 1'b0;
    cyc();
    chk("lockloss_err", obs(), 8'b0000_0001);
    cyc();
    chk("err_hold", obs(), 8'b0000_0001);
    lock_in = 1'b1;
    run_seq("rerun", 2, 1, 4'h5, 1'b1);

    // Abort during SYNC beats a simultaneous start.
    sync_len = 8'd10; settle_len = 8'd1; en_mask = 4'hF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("abort_pre", obs(), 8'b1000_0100);
    cyc();
    cyc();
    abort = 1'b1; start = 1'b1;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("abort", obs(), 8'h00);
    cyc();
    chk("abort_start_ign", obs(), 8'h00);

    // Reset in ENABLE after rx1 (ENABLE entry at cycle 3), reset wins over abort/start.
    sync_len = 8'd1; settle_len = 8'd0; en_mask = 4'hF;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_rst", obs(), 8'b0000_1100);
    rst = 1'b1; abort = 1'b1; start = 1'b1; stop = 1'b1;
    cyc();
    rst = 1'b0; abort = 1'b0; start = 1'b0; stop = 1'b0;
    chk("rst_enable", obs(), 8'h00);
    run_seq("post_rst", 0, 0, 4'hF, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adrv9001_sync_seq.md
ADRV9001_SYNC_SEQ -- requirements
Module: adrv9001_sync_seq

Interface -- parameters
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of all length inputs and internal counters.
REQ-002 SHALL have parameter STAGGER, default 4: cycles between successive channel-enable assertions (range 1..255).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum cycles to wait for lock_in.

Interface -- ports
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle request to run the sync sequence.
REQ-007 SHALL have port stop  input  1  orderly shutdown from ACTIVE.
REQ-008 SHALL have port abort  input  1  immediate return to IDLE from any state.
REQ-009 SHALL have port sync_len  input  CNT_WIDTH  mssi_sync pulse length in cycles.
REQ-010 SHALL have port settle_len  input  CNT_WIDTH  post-sync settle cycles.
REQ-011 SHALL have port en_mask  input  4  channel select, bit0 rx1, bit1 rx2, bit2 tx1, bit3 tx2.
REQ-012 SHALL have port lock_in  input  1  SSI interface locked status.
REQ-013 SHALL have port mssi_sync  output  1  multi-chip sync pulse to the transceiver.
REQ-014 SHALL have port rx1_en, rx2_en, tx1_en, tx2_en  output  1 each  channel enables.
REQ-015 SHALL have ports busy, done, err  output  1 each  status.

Function
REQ-016 SHALL implement states IDLE, SYNC, SETTLE, WAIT_LOCK, ENABLE, ACTIVE, ERROR, all outputs registered.
REQ-017 SHALL latch sync_len, settle_len, en_mask on the cycle start is accepted; later changes ignored until next start.
REQ-018 SHALL accept start only in IDLE or ERROR; start in other states ignored; accept clears err.
REQ-019 SHALL enter SYNC the cycle after start, driving mssi_sync high for exactly max(sync_len,1) cycles.
REQ-020 SHALL stay in SETTLE exactly settle_len cycles; settle_len=0 goes directly SYNC->WAIT_LOCK.
REQ-021 WAIT_LOCK: lock_in high -> ENABLE next cycle; LOCK_TIMEOUT cycles without lock_in -> ERROR.
REQ-022 ENABLE: assert masked enables in order rx1, rx2, tx1, tx2, first on ENABLE entry cycle+1, subsequent STAGGER cycles apart; unmasked channels skipped at zero cost; enables stay high once set.
REQ-023 en_mask=0 SHALL pass ENABLE in one cycle to ACTIVE with no enable asserted.
REQ-024 ACTIVE: done=1; stop -> IDLE, all enables and done low next cycle.
REQ-025 lock_in low during ENABLE or ACTIVE SHALL go to ERROR: enables low, done low, err=1 next cycle.
REQ-026 ERROR: err held high, enables low, until accepted start or rst.
REQ-027 abort SHALL take precedence over start, stop and lock loss: IDLE next cycle, mssi_sync, enables, done low, err cleared.
REQ-028 stop outside ACTIVE SHALL be ignored.
REQ-029 busy SHALL be high in SYNC, SETTLE, WAIT_LOCK, ENABLE; low otherwise.
REQ-030 Counters SHALL saturate, never wrap; sync_len/settle_len all-ones SHALL run 2^CNT_WIDTH-1 cycles.

Reset
REQ-031 rst SHALL force IDLE, all outputs 0, counters and latched config cleared, on the next rising edge, from any state.
REQ-032 rst SHALL override abort, start and stop in the same cycle.

Verification
REQ-033 start, sync_len=3, settle_len=2, en_mask=0xF, lock_in high -> mssi_sync high cycles 1-3, rx1_en cycle 7, rx2_en 11, tx1_en 15, tx2_en 19, done at 19.
REQ-034 start, lock_in held low -> busy 1 then err=1 exactly LOCK_TIMEOUT cycles after WAIT_LOCK entry; enables never assert.
REQ-035 en_mask=0x5, ACTIVE, drop lock_in -> rx1_en, tx1_en fall next cycle, err=1; new start clears err and reruns.
REQ-036 abort during SYNC with sync_len=10 -> mssi_sync low next cycle, busy 0, state IDLE; start same cycle as abort ignored.
REQ-037 rst asserted in ENABLE after rx1_en set -> all outputs 0 next edge; sync_len=0 run afterwards gives 1-cycle mssi_sync.
